// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU front-end arbiter.
package alu_arbiter_pkg;

  localparam int unsigned FLAG_LAT_DEF = 3;
  localparam int unsigned N_REQ        = 2;
  localparam int unsigned FUNSEL_W     = 5;
  localparam int unsigned FLAGS_W      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Control half of an ALU issue; operands travel separately since W is a module parameter.
  typedef struct packed {
    logic [FUNSEL_W-1:0] funsel;
    logic                cin;
  } op_ctl_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone request wins, contention goes to the side not served last.
module rr_arbiter_2
  import alu_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; one operation in flight, response after FLAG_LAT+1 busy edges.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned FLAG_LAT = FLAG_LAT_DEF,
  parameter int unsigned W        = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [FUNSEL_W-1:0] req_funsel0,
  input  logic [FUNSEL_W-1:0] req_funsel1,
  input  logic [W-1:0]        req_a0,
  input  logic [W-1:0]        req_a1,
  input  logic [W-1:0]        req_b0,
  input  logic [W-1:0]        req_b1,
  input  logic [N_REQ-1:0]    req_cin,
  output logic [FUNSEL_W-1:0] alu_funsel,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic                alu_cin,
  input  logic [W-1:0]        alu_out,
  input  logic [FLAGS_W-1:0]  alu_flags,
  output logic                resp_valid,
  output logic                resp_id,
  output logic [W-1:0]        resp_result,
  output logic [FLAGS_W-1:0]  resp_flags
);

  localparam int unsigned CNT_W = $clog2(FLAG_LAT + 2);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last;
  logic [N_REQ-1:0] w_gnt;
  logic             w_sel;
  logic             w_accept;
  logic             w_done;
  op_ctl_t          w_ctl;

  rr_arbiter_2 u_rr (
    .req  (req_valid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_sel = w_gnt[1];
  assign w_ctl = w_sel ? {req_funsel1, req_cin[1]} : {req_funsel0, req_cin[0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is the grant, but only while nothing is in flight.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = w_gnt;
        if (|(req_valid & w_gnt)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU drive registers hold the last accepted operation until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_funsel <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      r_owner    <= 1'b0;
    end else if (w_accept) begin
      alu_funsel <= w_ctl.funsel;
      alu_cin    <= w_ctl.cin;
      alu_a      <= w_sel ? req_a1 : req_a0;
      alu_b      <= w_sel ? req_b1 : req_b0;
      r_owner    <= w_sel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_W'(FLAG_LAT);
    end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Reset leaves last-served at 1 so requester 0 wins the first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      r_last      <= 1'b1;
    end else begin
      resp_valid <= w_done;
      if (w_done) begin
        resp_result <= alu_out;
        resp_flags  <= alu_flags;
        resp_id     <= r_owner;
        r_last      <= r_owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 3;
  localparam int          OCC = LAT + 2;

  typedef struct {
    logic [FUNSEL_W-1:0] f;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic                cin;
  } op_t;

  typedef struct {
    logic               id;
    logic [W-1:0]       res;
    logic [FLAGS_W-1:0] flg;
    int                 due;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [FUNSEL_W-1:0] req_funsel0, req_funsel1;
  logic [W-1:0]        req_a0, req_a1, req_b0, req_b1;
  logic [1:0]          req_cin;
  logic [FUNSEL_W-1:0] alu_funsel;
  logic [W-1:0]        alu_a, alu_b, alu_out;
  logic                alu_cin;
  logic [FLAGS_W-1:0]  alu_flags;
  logic                resp_valid, resp_id;
  logic [W-1:0]        resp_result;
  logic [FLAGS_W-1:0]  resp_flags;

  op_t        cur0, cur1, exp_alu;
  logic [1:0] act;
  op_t        rq0[$];
  op_t        rq1[$];
  exp_t       sb[$];
  int         checks, errors, cyc, mdl_free;
  logic       mdl_last, rnd_gap;
  logic               mon_id;
  logic [W-1:0]       mon_res;
  logic [FLAGS_W-1:0] mon_flg;

  always #5 clock = ~clock;

  // Reference ALU: flags packed Z|C|N|V, C is carry for add and borrow for subtract.
  function automatic logic [W+3:0] alu_ref(input logic [FUNSEL_W-1:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (f)
      5'b10100: begin
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      5'b10110: begin
        r = a - b;
        c = (a < b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      5'b00000: r = {{(W-16){a[15]}}, a[15:0]};
      5'b00001: r = a & b;
      5'b00011: r = a ^ b;
      default:  r = a + {{(W-FUNSEL_W){1'b0}}, f};
    endcase
    return {(r == '0), c, r[W-1], v, r};
  endfunction

  assign {alu_flags, alu_out} = alu_ref(alu_funsel, alu_a, alu_b, alu_cin);
  assign req_valid   = act;
  assign req_funsel0 = cur0.f;
  assign req_funsel1 = cur1.f;
  assign req_a0      = cur0.a;
  assign req_a1      = cur1.a;
  assign req_b0      = cur0.b;
  assign req_b1      = cur1.b;
  assign req_cin     = {cur1.cin, cur0.cin};

  alu_arbiter #(.FLAG_LAT(LAT), .W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funsel0 (req_funsel0),
    .req_funsel1 (req_funsel1),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .req_cin     (req_cin),
    .alu_funsel  (alu_funsel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cin     (alu_cin),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_flags  (resp_flags)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  function automatic op_t mk(input logic [FUNSEL_W-1:0] f, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic cin);
    op_t o;
    o.f = f;
    o.a = a;
    o.b = b;
    o.cin = cin;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 5))
      0:       o.f = 5'b10100;
      1:       o.f = 5'b10110;
      2:       o.f = 5'b00000;
      3:       o.f = 5'b00001;
      4:       o.f = 5'b00011;
      default: o.f = FUNSEL_W'($urandom);
    endcase
    o.a   = W'($urandom);
    o.b   = ($urandom_range(0, 7) == 0) ? o.a : W'($urandom);
    o.cin = 1'($urandom);
    return o;
  endfunction

  // One clock: check arbitration and ALU drive, log any accept, then update requesters.
  task automatic step();
    logic [1:0]     fire;
    logic [1:0]     exp_rdy;
    logic [W+3:0]   r;
    op_t            op;
    exp_t           e;
    @(negedge clock);
    exp_rdy = 2'b00;
    if (cyc >= mdl_free)
      exp_rdy = (act == 2'b11) ? (mdl_last ? 2'b01 : 2'b10) : act;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("alu_ab", {alu_a, alu_b}, {exp_alu.a, exp_alu.b});
    chk("alu_ctl", 64'({alu_funsel, alu_cin}), 64'({exp_alu.f, exp_alu.cin}));
    fire = act & req_ready;
    if (reset_n && fire != 2'b00) begin
      op    = fire[1] ? cur1 : cur0;
      r     = alu_ref(op.f, op.a, op.b, op.cin);
      e.id  = fire[1];
      e.res = r[W-1:0];
      e.flg = r[W+3:W];
      e.due = cyc + OCC;
      sb.push_back(e);
      mdl_free = cyc + OCC;
      mdl_last = fire[1];
      exp_alu  = op;
    end
    @(posedge clock);
    cyc++;
    #1;
    act = act & ~fire;
    if (!act[0] && rq0.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
      cur0   = rq0.pop_front();
      act[0] = 1'b1;
    end
    if (!act[1] && rq1.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
      cur1   = rq1.pop_front();
      act[1] = 1'b1;
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected @cycle %0d: got id=%0d result=%h, required no response",
                 cyc, resp_id, resp_result);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_result", 64'(resp_result), 64'(e.res));
        chk("resp_flags", 64'(resp_flags), 64'(e.flg));
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        mon_id  = e.id;
        mon_res = e.res;
        mon_flg = e.flg;
      end
    end else begin
      chk("resp_hold_idflg", 64'({resp_id, resp_flags}), 64'({mon_id, mon_flg}));
      chk("resp_hold_result", 64'(resp_result), 64'(mon_res));
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missing @cycle %0d: got no response, required one at cycle %0d",
                 cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    act      = 2'b00;
    sb.delete();
    rq0.delete();
    rq1.delete();
    mdl_free = 0;
    mdl_last = 1'b1;
    exp_alu  = mk('0, '0, '0, 1'b0);
    mon_id   = 1'b0;
    mon_res  = '0;
    mon_flg  = '0;
    repeat (3) begin
      step();
      chk("rst_resp", 64'({resp_valid, resp_id, resp_flags}), 64'(0));
      chk("rst_result", 64'(resp_result), 64'(0));
    end
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rq0.size() + rq1.size() != 0 || act != 2'b00 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (rq0.size() + rq1.size() != 0 || act != 2'b00 || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout @cycle %0d: got %0d responses outstanding, required 0", cyc, sb.size());
    end
    repeat (2) step();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rnd_gap = 1'b0;
    cur0    = mk('0, '0, '0, 1'b0);
    cur1    = mk('0, '0, '0, 1'b0);
    reset_n = 1'b0;
    act     = 2'b00;
    fork
      forever begin
        @(negedge clock);
        mon_step();
      end
    join_none
    apply_reset();

    // single op from requester 0
    rq0.push_back(mk(5'b10100, 32'd5, 32'd7, 1'b0));
    drain(50);

    // contention straight after reset: 0 first, then alternating
    apply_reset();
    repeat (3) begin
      rq0.push_back(rand_op());
      rq1.push_back(rand_op());
    end
    drain(100);

    // zero flag from requester 1, then sign-extended 16-bit op
    rq1.push_back(mk(5'b10110, 32'd3, 32'd3, 1'b0));
    drain(50);
    rq0.push_back(mk(5'b00000, 32'h0000_8001, 32'h1234_5678, 1'b0));
    drain(50);

    // requester 1 arrives while requester 0 is busy
    rq0.push_back(rand_op());
    step();
    step();
    rq1.push_back(rand_op());
    drain(50);

    // reset two edges into an operation, then a normal op
    rq0.push_back(rand_op());
    begin
      int n;
      n = 0;
      while (sb.size() == 0 && n < 20) begin
        step();
        n++;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL midop_accept @cycle %0d: got no accept, required one", cyc);
      end
    end
    step();
    step();
    apply_reset();
    repeat (6) step();
    rq1.push_back(rand_op());
    drain(50);

    // randomized traffic with gaps
    rnd_gap = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) rq0.push_back(rand_op());
      else                           rq1.push_back(rand_op());
    end
    drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
